// File: rtl/core_pkg.sv
// Shared core types: ALU opcode encoding, datapath width and branch-op classification.
package core_pkg;

  localparam int unsigned Xlen      = 32;
  localparam int unsigned MaxAluReq = 8;

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpXor, OpOr, OpAnd, OpSll, OpSrl, OpSra,
    OpSlt, OpSltu, OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu
  } alu_op_e;

  function automatic logic is_branch_op(alu_op_e op);
    return op inside {OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu};
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU; branch_take_o is only defined for branch opcodes.
module alu
  import core_pkg::*;
(
  input  alu_op_e          op_i,
  input  logic [Xlen-1:0]  a_i,
  input  logic [Xlen-1:0]  b_i,
  output logic [Xlen-1:0]  res_o,
  output logic             branch_take_o
);

  always_comb begin
    res_o         = '0;
    branch_take_o = 1'bx;
    unique case (op_i)
      OpAdd:  res_o = a_i + b_i;
      OpSub:  res_o = a_i - b_i;
      OpXor:  res_o = a_i ^ b_i;
      OpOr:   res_o = a_i | b_i;
      OpAnd:  res_o = a_i & b_i;
      OpSll:  res_o = a_i << b_i[4:0];
      OpSrl:  res_o = a_i >> b_i[4:0];
      OpSra:  res_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      OpSlt:  res_o = Xlen'($signed(a_i) < $signed(b_i));
      OpSltu: res_o = Xlen'(a_i < b_i);
      OpBeq:  branch_take_o = (a_i == b_i);
      OpBne:  branch_take_o = (a_i != b_i);
      OpBlt:  branch_take_o = ($signed(a_i) < $signed(b_i));
      OpBge:  branch_take_o = ($signed(a_i) >= $signed(b_i));
      OpBltu: branch_take_o = (a_i < b_i);
      OpBgeu: branch_take_o = (a_i >= b_i);
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_picker.sv
// Round-robin priority picker: first valid requester at or after ptr_i, wrapping modulo N.
module rr_picker #(
  parameter int unsigned N   = 2,
  parameter int unsigned IdW = $clog2(N)
) (
  input  logic [N-1:0]   valid_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [IdW-1:0] grant_id_o,
  output logic           grant_vld_o
);

  int unsigned idx;

  // Scan farthest-to-nearest so the nearest valid slot after ptr_i is written last.
  always_comb begin
    grant_id_o = '0;
    idx        = 0;
    for (int unsigned k = N; k > 0; k--) begin
      idx = (int'(ptr_i) + k - 1) % N;
      if (valid_i[idx]) grant_id_o = IdW'(idx);
    end
    grant_vld_o = |valid_i;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NumReq requesters, with a one-entry
// registered response slot that can drain and refill in the same cycle.
module alu_arbiter
  import core_pkg::*;
#(
  parameter int unsigned NumReq = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic    [NumReq-1:0]           req_valid_i,
  output logic    [NumReq-1:0]           req_ready_o,
  input  alu_op_e [NumReq-1:0]           req_op_i,
  input  logic    [NumReq-1:0][Xlen-1:0] req_a_i,
  input  logic    [NumReq-1:0][Xlen-1:0] req_b_i,
  output logic    [NumReq-1:0]           resp_valid_o,
  input  logic    [NumReq-1:0]           resp_ready_i,
  output logic    [Xlen-1:0]             resp_res_o,
  output logic                           resp_branch_take_o,
  output logic                           busy_o
);

  localparam int unsigned IdW = $clog2(NumReq);

  logic [IdW-1:0]  rr_q;
  logic            out_valid_q;
  logic [IdW-1:0]  out_id_q;
  logic [Xlen-1:0] out_res_q;
  logic            out_br_q;

  logic [IdW-1:0]  grant_id;
  logic            grant_vld;
  logic            slot_free;
  logic            accept;
  alu_op_e         alu_op;
  logic [Xlen-1:0] alu_res;
  logic            alu_br;

  rr_picker #(.N(NumReq), .IdW(IdW)) u_rr_picker (
    .valid_i     (req_valid_i),
    .ptr_i       (rr_q),
    .grant_id_o  (grant_id),
    .grant_vld_o (grant_vld)
  );

  // grant_id defaults to 0 when idle, so the ALU then sees requester 0.
  assign alu_op = req_op_i[grant_id];

  alu u_alu (
    .op_i          (alu_op),
    .a_i           (req_a_i[grant_id]),
    .b_i           (req_b_i[grant_id]),
    .res_o         (alu_res),
    .branch_take_o (alu_br)
  );

  assign slot_free = !out_valid_q || resp_ready_i[out_id_q];
  // rst_ni gating keeps ready low during reset without waiting for a clock.
  assign accept    = grant_vld && slot_free && rst_ni;

  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    if (accept) req_ready_o[grant_id] = 1'b1;
    if (out_valid_q) resp_valid_o[out_id_q] = 1'b1;
  end

  assign resp_res_o         = out_res_q;
  assign resp_branch_take_o = out_br_q;
  assign busy_o             = out_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_res_q   <= '0;
      out_br_q    <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_id_q    <= grant_id;
      out_res_q   <= alu_res;
      out_br_q    <= is_branch_op(alu_op) ? alu_br : 1'b0;
      rr_q        <= (int'(grant_id) == NumReq - 1) ? '0 : grant_id + 1'b1;
    end else if (slot_free) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two requesters.
module tb_alu_arbiter;
  import core_pkg::*;

  logic                    clk;
  logic                    rst_n;
  logic    [1:0]           req_valid;
  logic    [1:0]           req_ready;
  alu_op_e [1:0]           req_op;
  logic    [1:0][Xlen-1:0] req_a;
  logic    [1:0][Xlen-1:0] req_b;
  logic    [1:0]           resp_valid;
  logic    [1:0]           resp_ready;
  logic    [Xlen-1:0]      resp_res;
  logic                    resp_br;
  logic                    busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  alu_arbiter #(.NumReq(2)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_op_i           (req_op),
    .req_a_i            (req_a),
    .req_b_i            (req_b),
    .resp_valid_o       (resp_valid),
    .resp_ready_i       (resp_ready),
    .resp_res_o         (resp_res),
    .resp_branch_take_o (resp_br),
    .busy_o             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  exp_ready [4];
    logic [1:0]  exp_resp  [4];
    logic [31:0] exp_res   [4];
    exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_resp  = '{2'b00, 2'b01, 2'b10, 2'b01};
    exp_res   = '{32'h0, 32'h7, 32'hFF, 32'h7};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_op     = {OpAdd, OpAdd};
    req_a      = '0;
    req_b      = '0;
    resp_ready = 2'b11;

    // Reset state
    #12;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_res", resp_res, 32'h0);
    chk("rst_br", 32'(resp_br), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nx();

    // Single op
    req_valid = 2'b01; req_op[0] = OpAdd; req_a[0] = 32'd5; req_b[0] = 32'd7;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_busy0", 32'(busy), 32'h0);
    nx();
    req_valid = '0;
    @(negedge clk);
    chk("single_resp_valid", 32'(resp_valid), 32'h1);
    chk("single_res", resp_res, 32'd12);
    chk("single_br", 32'(resp_br), 32'h0);
    chk("single_busy1", 32'(busy), 32'h1);
    nx();
    @(negedge clk);
    chk("single_busy2", 32'(busy), 32'h0);
    chk("single_resp_idle", 32'(resp_valid), 32'h0);

    // Contention from reset
    nx();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nx();
    req_valid = 2'b11;
    req_op[0] = OpSub; req_a[0] = 32'd10;  req_b[0] = 32'd3;
    req_op[1] = OpXor; req_a[1] = 32'hF0;  req_b[1] = 32'h0F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("cont_ready_%0d", i), 32'(req_ready), 32'(exp_ready[i]));
      chk($sformatf("cont_resp_valid_%0d", i), 32'(resp_valid), 32'(exp_resp[i]));
      if (i > 0) chk($sformatf("cont_res_%0d", i), resp_res, exp_res[i]);
      nx();
    end
    req_valid = '0;
    @(negedge clk);
    chk("cont_resp_valid_4", 32'(resp_valid), 32'h2);
    chk("cont_res_4", resp_res, 32'hFF);
    nx();

    // Backpressure
    req_valid = 2'b10; req_op[1] = OpBlt; req_a[1] = 32'hFFFF_FFFF; req_b[1] = 32'd1;
    @(negedge clk);
    chk("bp_ready_req1", 32'(req_ready), 32'h2);
    nx();
    req_valid = 2'b01; req_op[0] = OpAdd; req_a[0] = 32'd1; req_b[0] = 32'd2;
    resp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_resp_valid_%0d", i), 32'(resp_valid), 32'h2);
      chk($sformatf("bp_br_%0d", i), 32'(resp_br), 32'h1);
      chk($sformatf("bp_ready_%0d", i), 32'(req_ready), 32'h0);
      chk($sformatf("bp_busy_%0d", i), 32'(busy), 32'h1);
      nx();
    end
    resp_ready = 2'b11;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'h1);
    chk("bp_release_resp", 32'(resp_valid), 32'h2);
    nx();
    req_valid = '0;
    @(negedge clk);
    chk("bp_refill_resp", 32'(resp_valid), 32'h1);
    chk("bp_refill_res", resp_res, 32'd3);
    nx();

    // Branch masking
    req_valid = 2'b01; req_op[0] = OpBeq; req_a[0] = 32'h1234; req_b[0] = 32'h1234;
    @(negedge clk);
    chk("br_ready0", 32'(req_ready), 32'h1);
    nx();
    req_op[0] = OpSll; req_a[0] = 32'd1; req_b[0] = 32'd4;
    @(negedge clk);
    chk("br_ready1", 32'(req_ready), 32'h1);
    chk("br_beq_take", 32'(resp_br), 32'h1);
    chk("br_beq_valid", 32'(resp_valid), 32'h1);
    nx();
    req_valid = '0;
    @(negedge clk);
    chk("br_sll_res", resp_res, 32'd16);
    chk("br_sll_take", 32'(resp_br), 32'h0);
    nx();

    // Async reset mid-operation
    req_valid = 2'b10; req_op[1] = OpOr; req_a[1] = 32'd3; req_b[1] = 32'd4;
    resp_ready = 2'b01;
    @(negedge clk);
    chk("ar_ready_req1", 32'(req_ready), 32'h2);
    nx();
    req_valid = 2'b11; req_op[0] = OpAdd; req_a[0] = 32'd1; req_b[0] = 32'd1;
    @(negedge clk);
    chk("ar_resp_valid", 32'(resp_valid), 32'h2);
    chk("ar_res", resp_res, 32'd7);
    chk("ar_ready_held", 32'(req_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_resp_valid_rst", 32'(resp_valid), 32'h0);
    chk("ar_busy_rst", 32'(busy), 32'h0);
    chk("ar_ready_rst", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 2'b11;
    #1;
    chk("ar_first_grant", 32'(req_ready), 32'h1);
    nx();
    req_valid = '0;
    @(negedge clk);
    chk("ar_first_resp", 32'(resp_valid), 32'h1);
    chk("ar_first_res", resp_res, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance between NumReq requesters, e.g. the integer execute stage and the branch-resolution unit.
- Per-requester valid/ready request channel; round-robin grant.
- One-entry registered response slot returns result and branch decision to the owning requester one cycle after acceptance.
- Sits in the execute stage between issue logic and the ALU datapath.

Parameters:
- NumReq, 2, number of requesters; legal range 2..8.
- IdW, $clog2(NumReq), width of requester index; derived, not overridable.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  per-requester request accepted this cycle.
- req_op_i  in  NumReq x alu_op_e  per-requester ALU operation.
- req_a_i  in  NumReq x Xlen  per-requester operand a.
- req_b_i  in  NumReq x Xlen  per-requester operand b.
- resp_valid_o  out  NumReq  one-hot response valid to the owning requester.
- resp_ready_i  in  NumReq  per-requester response consumed.
- resp_res_o  out  Xlen  result, shared bus; meaningful only where resp_valid_o is set.
- resp_branch_take_o  out  1  branch decision, shared bus.
- busy_o  out  1  response slot occupied.

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - rr_q=0, out_valid_q=0, out_id_q=0, out_res_q=0, out_br_q=0.
  - Outputs: req_ready_o=0, resp_valid_o=0, resp_res_o=0, resp_branch_take_o=0, busy_o=0.
- Slot free condition: slot_free = !out_valid_q || resp_ready_i[out_id_q].
  - A full slot may be drained and refilled in the same cycle, giving back-to-back throughput of 1 op/cycle.
- Grant selection:
  - Search requesters in order rr_q, rr_q+1, … modulo NumReq.
  - grant_id is the first requester with req_valid_i set; grant_vld = |req_valid_i.
  - Purely combinational.
- Ready and acceptance:
  - req_ready_o[i] = grant_vld && slot_free && (grant_id==i). At most one bit is set.
  - req_ready_o may depend on req_valid_i. Requesters must not make valid depend on ready.
- On acceptance (grant_vld && slot_free):
  - The `alu` is driven combinationally with req_op_i/req_a_i/req_b_i[grant_id].
  - Next-edge updates: out_valid_q<=1, out_id_q<=grant_id, out_res_q<=alu res_o.
  - out_br_q <= is_branch_op(op) ? branch_take_o : 0. This masks the X the ALU produces for non-branch ops.
  - rr_q <= (grant_id==NumReq-1) ? 0 : grant_id+1.
- When slot_free && !grant_vld: out_valid_q<=0. Other registers hold; out_res_q/out_br_q keep their last value.
- When the slot is not free, every register holds and all req_ready_o are 0. This is backpressure, and the output is stable while resp_valid_o is set.
- Output drive:
  - resp_valid_o[i] = out_valid_q && out_id_q==i.
  - resp_res_o=out_res_q; resp_branch_take_o=out_br_q; busy_o=out_valid_q.
- Latency: request accepted at edge N → response visible after edge N, i.e. in cycle N+1.
- Fairness: a continuously-valid requester is granted within NumReq accepted ops.
- rr_q advances only on a grant, never on idle cycles.
- Inputs of non-granted requesters are ignored. A requester may drop valid before it is accepted.
- When no grant, drive ALU inputs from requester 0. Its outputs are unused.
- Reset mid-operation: a pending response is discarded and no resp_valid_o is seen after reset. Requesters must reissue.

Decomposition:
- core_pkg additions:
  - function is_branch_op(alu_op_e) → 1 for OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu.
  - localparam MaxAluReq=8.
- Sub-modules:
  - Instantiate the existing `alu` once; it is the only datapath.
  - Round-robin priority picker as sub-module rr_picker (inputs: valid vector, pointer; outputs: grant_id, grant_vld). It is reusable by later arbiters.

Test Plan:
- Reset then single op:
  - Stimulus: req0 OpAdd a=5 b=7, resp_ready all 1.
  - Required: req_ready_o=01 in cycle 0; resp_valid_o=01, resp_res_o=12, resp_branch_take_o=0 in cycle 1; busy_o back to 0 in cycle 2.
- Contention:
  - Stimulus: both valid continuously from reset; req0 OpSub 10-3, req1 OpXor 0xF0^0x0F; resp_ready=11.
  - Required: grants alternate 0,1,0,1; responses 7, 0xFF, 7, 0xFF on resp_valid_o 01, 10, 01, 10; one op per cycle.
- Backpressure:
  - Stimulus: req1 OpBlt a=-1 b=1; resp_ready_i[1]=0 for 3 cycles; req0 valid meanwhile.
  - Required: resp_valid_o=10 with branch_take=1 held stable 3 cycles; req_ready_o=00 throughout.
  - On the cycle resp_ready_i[1] rises, req0 is accepted in the same cycle.
- Branch masking:
  - Stimulus: req0 OpBeq a=b=0x1234, then OpSll a=1 b=4.
  - Required: branch_take=1 with the first response; second response has res=16, branch_take=0 (never X).
- Async reset mid-operation:
  - Stimulus: assert rst_ni low between clock edges while resp_valid_o=10.
  - Required: resp_valid_o, busy_o and req_ready_o go 0 immediately without a clock; after release, the first grant goes to requester 0 (rr_q=0).
